// File: rtl/cdb_pkg.sv
// Shared constants and payload type for the CDB completion arbiter.
package cdb_pkg;

    localparam int unsigned NUM_REQ = 5;
    localparam int unsigned SRC_W   = 3;

    localparam logic [SRC_W-1:0] SRC_ALU  = 3'd0;
    localparam logic [SRC_W-1:0] SRC_MUL  = 3'd1;
    localparam logic [SRC_W-1:0] SRC_DIV  = 3'd2;
    localparam logic [SRC_W-1:0] SRC_LOAD = 3'd3;
    localparam logic [SRC_W-1:0] SRC_CSR  = 3'd4;

    typedef struct packed {
        logic [31:0] value;
        logic [31:0] inst_num;
        logic        exc;
        logic [1:0]  cause;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester completion inputs and the registered CDB broadcast of cdb_arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned NUM_REQ = cdb_pkg::NUM_REQ
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*32-1:0]   req_value;
    logic [NUM_REQ*32-1:0]   req_inst_num;
    logic [NUM_REQ-1:0]      req_exc;
    logic [NUM_REQ*2-1:0]    req_cause;

    logic                    cdb_valid;
    logic [31:0]             cdb_value;
    logic [31:0]             cdb_inst_num;
    logic                    cdb_exc;
    logic [1:0]              cdb_cause;
    logic [cdb_pkg::SRC_W-1:0] cdb_src;

    modport master (
        output req_valid, req_value, req_inst_num, req_exc, req_cause,
        input  req_ready,
        input  cdb_valid, cdb_value, cdb_inst_num, cdb_exc, cdb_cause, cdb_src
    );

    modport slave (
        input  req_valid, req_value, req_inst_num, req_exc, req_cause,
        output req_ready,
        output cdb_valid, cdb_value, cdb_inst_num, cdb_exc, cdb_cause, cdb_src
    );

endinterface

// File: rtl/cdb_req_fifo.sv
// Per-requester completion queue with registered full/empty flags and synchronous flush.
module cdb_req_fifo
    import cdb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  cdb_entry_t din,
    input  logic       pop,
    output cdb_entry_t dout,
    output logic       full,
    output logic       empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    cdb_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_en, pop_en;

    // Flush wins over both push and pop; full is the start-of-cycle flag.
    assign push_en = push && !full_q && !flush;
    assign pop_en  = pop && !empty_q && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_en && !pop_en)      count_d = count_q + 1'b1;
            else if (!push_en && pop_en) count_d = count_q - 1'b1;
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin completion arbiter: per-source queues drained one entry per cycle onto the CDB.
// Define CDB_PERF_EN to build the perf_full_cycles queue-full stall counter.
module cdb_arbiter #(
    parameter int unsigned QDEPTH  = 2,
    parameter int unsigned NUM_REQ = cdb_pkg::NUM_REQ
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    cdb_arbiter_if.slave bus
`ifdef CDB_PERF_EN
    ,
    output logic [15:0]  perf_full_cycles
`endif
);
    import cdb_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    cdb_entry_t         head [NUM_REQ];
    logic [NUM_REQ-1:0] full, empty, pop;

    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   rr_q, rr_d;

    logic               cdb_valid_q, cdb_valid_d;
    cdb_entry_t         cdb_entry_q, cdb_entry_d;
    logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        cdb_entry_t din;

        assign din = '{value:    bus.req_value[32*g +: 32],
                       inst_num: bus.req_inst_num[32*g +: 32],
                       exc:      bus.req_exc[g],
                       cause:    bus.req_cause[2*g +: 2]};

        cdb_req_fifo #(
            .DEPTH (QDEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (bus.req_valid[g]),
            .din   (din),
            .pop   (pop[g]),
            .dout  (head[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    assign bus.req_ready = ~full;

    // First non-empty queue at or after rr, wrapping.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_q) + k) % NUM_REQ;
            if (!grant_vld && !empty[IDX_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        rr_d        = rr_q;
        pop         = '0;
        cdb_valid_d = 1'b0;
        cdb_entry_d = '0;
        cdb_src_d   = '0;
        if (grant_vld && !flush) begin
            rr_d           = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            pop[grant_idx] = 1'b1;
            cdb_valid_d    = 1'b1;
            cdb_entry_d    = head[grant_idx];
            cdb_src_d      = SRC_W'(grant_idx);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q        <= '0;
            cdb_valid_q <= 1'b0;
            cdb_entry_q <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_entry_q <= cdb_entry_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign bus.cdb_valid    = cdb_valid_q;
    assign bus.cdb_value    = cdb_entry_q.value;
    assign bus.cdb_inst_num = cdb_entry_q.inst_num;
    assign bus.cdb_exc      = cdb_entry_q.exc;
    assign bus.cdb_cause    = cdb_entry_q.cause;
    assign bus.cdb_src      = cdb_src_q;

`ifdef CDB_PERF_EN
    logic [15:0] perf_q;

    // Survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (|full && perf_q != 16'hFFFF) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_full_cycles = perf_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NREQ = 5;
  localparam int QD   = 2;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_checks = 0;
  int   n_errors = 0;

  cdb_arbiter_if #(.NUM_REQ(NREQ)) bus ();

`ifdef CDB_PERF_EN
  logic [15:0] perf;
`endif

  cdb_arbiter #(
    .QDEPTH  (QD),
    .NUM_REQ (NREQ)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef CDB_PERF_EN
    ,
    .perf_full_cycles (perf)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: one FIFO queue per requester plus the round-robin pointer.
  cdb_entry_t  mq [NREQ][$];
  int          m_rr;
  logic        m_valid;
  cdb_entry_t  m_ent;
  logic [2:0]  m_src;
  int          m_perf;

  function automatic logic [70:0] obs_cdb();
    return {bus.cdb_valid, bus.cdb_value, bus.cdb_inst_num, bus.cdb_exc, bus.cdb_cause,
            bus.cdb_src};
  endfunction

  function automatic logic [70:0] exp_cdb();
    return {m_valid, m_ent.value, m_ent.inst_num, m_ent.exc, m_ent.cause, m_src};
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    for (int i = 0; i < NREQ; i++) r[i] = (mq[i].size() < QD);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) mq[i].delete();
    m_rr    = 0;
    m_valid = 1'b0;
    m_ent   = '0;
    m_src   = '0;
    m_perf  = 0;
  endtask

  task automatic model_edge();
    logic [NREQ-1:0] rdy;
    cdb_entry_t      e;
    int              g;
    int              j;
    rdy = exp_ready();
    if (rdy != '1 && m_perf < 65535) m_perf++;
    g = -1;
    if (flush) begin
      for (int i = 0; i < NREQ; i++) mq[i].delete();
      m_valid = 1'b0;
      m_ent   = '0;
      m_src   = '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_rr + k) % NREQ;
        if (g < 0 && mq[j].size() != 0) g = j;
      end
      if (g >= 0) begin
        m_valid = 1'b1;
        m_ent   = mq[g].pop_front();
        m_src   = 3'(g);
        m_rr    = (g + 1) % NREQ;
      end else begin
        m_valid = 1'b0;
        m_ent   = '0;
        m_src   = '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && rdy[i]) begin
          e.value    = bus.req_value[32*i +: 32];
          e.inst_num = bus.req_inst_num[32*i +: 32];
          e.exc      = bus.req_exc[i];
          e.cause    = bus.req_cause[2*i +: 2];
          mq[i].push_back(e);
        end
      end
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] val,
                         input logic [31:0] tag, input logic e, input logic [1:0] c);
    bus.req_valid[i]             = v;
    bus.req_value[32*i +: 32]    = val;
    bus.req_inst_num[32*i +: 32] = tag;
    bus.req_exc[i]               = e;
    bus.req_cause[2*i +: 2]      = c;
  endtask

  task automatic clear_reqs();
    bus.req_valid    = '0;
    bus.req_value    = '0;
    bus.req_inst_num = '0;
    bus.req_exc      = '0;
    bus.req_cause    = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    flush = 1'b0;
    clear_reqs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    flush = 1'b0;
    clear_reqs();
    model_reset();
    #1;
    n_checks++;
    if (obs_cdb() !== 71'd0) begin
      n_errors++;
      $display("FAIL reset_cdb: got %h expected 0", obs_cdb());
    end
`ifdef CDB_PERF_EN
    n_checks++;
    if (perf !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_perf: got %0d expected 0", perf);
    end
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cycle();
    n_checks++;
    if (bus.req_ready !== 5'b11111) begin
      n_errors++;
      $display("FAIL reset_ready: got %b expected 11111", bus.req_ready);
    end
    n_checks++;
    if (obs_cdb() !== 71'd0) begin
      n_errors++;
      $display("FAIL reset_idle: got %h expected 0", obs_cdb());
    end
  endtask

  task automatic test_single_alu();
    do_reset();
    set_req(0, 1'b1, 32'h1234, 32'd7, 1'b0, 2'b00);
    cycle();
    clear_reqs();
    n_checks++;
    if (bus.cdb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL alu_no_bypass: got valid=%b expected 0", bus.cdb_valid);
    end
    cycle();
    n_checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_value !== 32'h1234 || bus.cdb_inst_num !== 32'd7
        || bus.cdb_src !== 3'd0) begin
      n_errors++;
      $display("FAIL alu_bcast: got v=%b val=%h tag=%0d src=%0d expected v=1 val=1234 tag=7 src=0",
               bus.cdb_valid, bus.cdb_value, bus.cdb_inst_num, bus.cdb_src);
    end
    cycle();
    n_checks++;
    if (bus.cdb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL alu_after: got valid=%b expected 0", bus.cdb_valid);
    end
  endtask

  task automatic test_all_five();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'hA000_0000 + i, 100 + i, 1'b0, 2'b00);
    cycle();
    clear_reqs();
    for (int k = 0; k < NREQ; k++) begin
      cycle();
      n_checks++;
      if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 3'(k)
          || bus.cdb_value !== 32'hA000_0000 + k) begin
        n_errors++;
        $display("FAIL five_order%0d: got v=%b src=%0d val=%h expected v=1 src=%0d val=%h",
                 k, bus.cdb_valid, bus.cdb_src, bus.cdb_value, k, 32'hA000_0000 + k);
      end
    end
    // rr must have wrapped to ALU: with ALU and CSR both pending ALU goes first.
    set_req(0, 1'b1, 32'h11, 32'd1, 1'b0, 2'b00);
    set_req(4, 1'b1, 32'h44, 32'd4, 1'b0, 2'b00);
    cycle();
    clear_reqs();
    n_checks++;
    if (bus.cdb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL five_drained: got valid=%b expected 0", bus.cdb_valid);
    end
    cycle();
    n_checks++;
    if (bus.cdb_src !== 3'd0 || bus.cdb_value !== 32'h11) begin
      n_errors++;
      $display("FAIL five_rr_wrap: got src=%0d val=%h expected src=0 val=11",
               bus.cdb_src, bus.cdb_value);
    end
    cycle();
    n_checks++;
    if (bus.cdb_src !== 3'd4 || bus.cdb_value !== 32'h44) begin
      n_errors++;
      $display("FAIL five_rr_next: got src=%0d val=%h expected src=4 val=44",
               bus.cdb_src, bus.cdb_value);
    end
  endtask

  task automatic test_div_exc();
    set_req(2, 1'b1, 32'hD1D1_0002, 32'd42, 1'b1, 2'b01);
    cycle();
    clear_reqs();
    cycle();
    n_checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_exc !== 1'b1 || bus.cdb_cause !== 2'b01
        || bus.cdb_src !== 3'd2 || bus.cdb_inst_num !== 32'd42) begin
      n_errors++;
      $display("FAIL div_exc: got v=%b exc=%b cause=%b src=%0d tag=%0d expected 1 1 01 2 42",
               bus.cdb_valid, bus.cdb_exc, bus.cdb_cause, bus.cdb_src, bus.cdb_inst_num);
    end
  endtask

  task automatic test_contention();
    int prev;
    int n_alu;
    int n_load;
    bit saw_full;
    prev     = -1;
    n_alu    = 0;
    n_load   = 0;
    saw_full = 1'b0;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      set_req(0, 1'b1, $urandom, $urandom, 1'b0, 2'b00);
      set_req(3, 1'b1, $urandom, $urandom, 1'($urandom), 2'($urandom));
      cycle();
      n_checks++;
      if (obs_cdb() !== exp_cdb()) begin
        n_errors++;
        $display("FAIL cont_cdb c%0d: got %h expected %h", c, obs_cdb(), exp_cdb());
      end
      n_checks++;
      if (bus.req_ready !== exp_ready()) begin
        n_errors++;
        $display("FAIL cont_ready c%0d: got %b expected %b", c, bus.req_ready, exp_ready());
      end
      if (!bus.req_ready[3]) saw_full = 1'b1;
      if (bus.cdb_valid) begin
        if (bus.cdb_src == 3'd0) n_alu++;
        if (bus.cdb_src == 3'd3) n_load++;
        if (c >= 2) begin
          n_checks++;
          if (int'(bus.cdb_src) == prev || (bus.cdb_src != 3'd0 && bus.cdb_src != 3'd3)) begin
            n_errors++;
            $display("FAIL cont_alternate c%0d: got src=%0d after %0d expected the other",
                     c, bus.cdb_src, prev);
          end
        end
        prev = int'(bus.cdb_src);
      end
    end
    clear_reqs();
    n_checks++;
    if (!saw_full) begin
      n_errors++;
      $display("FAIL cont_load_full: got ready[3] never low expected a drop");
    end
    n_checks++;
    if (n_alu < 10 || n_load < 10) begin
      n_errors++;
      $display("FAIL cont_starve: got alu=%0d load=%0d expected >=10 each", n_alu, n_load);
    end
`ifdef CDB_PERF_EN
    n_checks++;
    if (int'(perf) !== m_perf || perf == 16'd0) begin
      n_errors++;
      $display("FAIL cont_perf: got %0d expected %0d (nonzero)", perf, m_perf);
    end
`endif
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'hF000_0000 + i, 200 + i, 1'b0, 2'b00);
    cycle();
    clear_reqs();
    set_req(1, 1'b1, 32'hF000_0011, 32'd211, 1'b0, 2'b00);
    cycle();
    n_checks++;
    if (bus.req_ready[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_mul_full: got ready[1]=%b expected 0", bus.req_ready[1]);
    end
    flush = 1'b1;
    set_req(1, 1'b1, 32'hDEAD_BEEF, 32'hBAD, 1'b0, 2'b00);
    cycle();
    flush = 1'b0;
    clear_reqs();
    n_checks++;
    if (bus.cdb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_edge1: got valid=%b expected 0", bus.cdb_valid);
    end
    n_checks++;
    if (bus.req_ready !== 5'b11111) begin
      n_errors++;
      $display("FAIL flush_ready: got %b expected 11111", bus.req_ready);
    end
    for (int c = 0; c < 5; c++) begin
      cycle();
      n_checks++;
      if (bus.cdb_valid !== 1'b0 || obs_cdb() !== exp_cdb()) begin
        n_errors++;
        $display("FAIL flush_quiet c%0d: got %h expected %h", c, obs_cdb(), exp_cdb());
      end
    end
`ifdef CDB_PERF_EN
    n_checks++;
    if (int'(perf) !== m_perf || perf == 16'd0) begin
      n_errors++;
      $display("FAIL flush_perf_kept: got %0d expected %0d (nonzero)", perf, m_perf);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NREQ; i++)
        set_req(i, ($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom),
                2'($urandom));
      cycle();
      n_checks++;
      if (obs_cdb() !== exp_cdb()) begin
        n_errors++;
        $display("FAIL rand_cdb c%0d: got %h expected %h", c, obs_cdb(), exp_cdb());
      end
      n_checks++;
      if (bus.req_ready !== exp_ready()) begin
        n_errors++;
        $display("FAIL rand_ready c%0d: got %b expected %b", c, bus.req_ready, exp_ready());
      end
`ifdef CDB_PERF_EN
      n_checks++;
      if (int'(perf) !== m_perf) begin
        n_errors++;
        $display("FAIL rand_perf c%0d: got %0d expected %0d", c, perf, m_perf);
      end
`endif
    end
    flush = 1'b0;
    clear_reqs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, $urandom, $urandom, 1'b0, 2'b00);
    cycle();
    cycle();
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (obs_cdb() !== 71'd0) begin
      n_errors++;
      $display("FAIL midrst_async: got %h expected 0", obs_cdb());
    end
    clear_reqs();
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    set_req(0, 1'b1, 32'h55, 32'd9, 1'b0, 2'b00);
    cycle();
    clear_reqs();
    n_checks++;
    if (bus.req_ready !== 5'b11111) begin
      n_errors++;
      $display("FAIL midrst_ready: got %b expected 11111", bus.req_ready);
    end
    cycle();
    n_checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_value !== 32'h55 || bus.cdb_inst_num !== 32'd9
        || bus.cdb_src !== 3'd0) begin
      n_errors++;
      $display("FAIL midrst_first: got v=%b val=%h tag=%0d src=%0d expected 1 55 9 0",
               bus.cdb_valid, bus.cdb_value, bus.cdb_inst_num, bus.cdb_src);
    end
    cycle();
    n_checks++;
    if (bus.cdb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_stale: got valid=%b src=%0d expected 0", bus.cdb_valid,
               bus.cdb_src);
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_all_five();
    test_div_exc();
    test_contention();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter QDEPTH, default 2, SHALL set per-requester queue depth in entries; legal values are 2 and 4.
REQ-002 Parameter NUM_REQ, default 5, SHALL set the requester count; slots are 0 ALU, 1 MUL, 2 DIV, 3 LOAD, 4 CSR.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 flush  in  1  SHALL be a synchronous pipeline flush, active-high.
REQ-006 req_valid  in  NUM_REQ  SHALL carry per-requester completion valid.
REQ-007 req_ready  out  NUM_REQ  SHALL carry per-requester accept, equal to the registered "queue not full" flag.
REQ-008 req_value  in  NUM_REQ*32  SHALL carry result values, requester i at bits [32i+31:32i].
REQ-009 req_inst_num  in  NUM_REQ*32  SHALL carry instruction tags, packed the same way as req_value.
REQ-010 req_exc  in  NUM_REQ  SHALL carry per-requester exception flags.
REQ-011 req_cause  in  NUM_REQ*2  SHALL carry exception causes, packed as 2-bit fields.
REQ-012 cdb_valid, cdb_value[31:0], cdb_inst_num[31:0], cdb_exc, cdb_cause[1:0], cdb_src[2:0]  out  SHALL form the registered single completion broadcast to the ROB.
REQ-013 perf_full_cycles  out  16  SHALL exist only when CDB_PERF_EN is defined.

Function
REQ-014 A requester transfer SHALL occur on a rising edge where req_valid[i] and req_ready[i] are both 1; the payload is pushed into queue i.
REQ-015 req_ready[i] SHALL be computed from queue occupancy at the start of the cycle; a same-cycle pop SHALL NOT raise ready for a full queue.
REQ-016 Each cycle, the arbiter SHALL pick one non-empty queue by round-robin, starting the search at pointer rr (0..NUM_REQ-1).
REQ-017 The picked queue head SHALL be popped and loaded into the cdb_* registers with cdb_valid=1 and cdb_src=i.
REQ-018 When no queue is non-empty, cdb_valid SHALL be 0 and the other cdb_* outputs SHALL be 0.
REQ-019 After a grant to queue i, rr SHALL become i+1, wrapping NUM_REQ-1 to 0; with no grant, rr SHALL hold.
REQ-020 Minimum latency from accept edge to cdb_valid SHALL be 1 cycle; there is no combinational bypass.
REQ-021 Each queue SHALL be FIFO ordered and support a simultaneous push and pop when not full; occupancy is then unchanged.
REQ-022 The per-requester payload SHALL be passed unmodified: value, inst_num, exc, cause.
REQ-023 Flush SHALL empty all queues and force cdb_valid=0 on the next edge; rr SHALL hold.
REQ-024 A push coinciding with flush SHALL be dropped.
REQ-025 A pop coinciding with flush SHALL be discarded and not broadcast.
REQ-026 req_ready SHALL be all-ones in the cycle after a flush.

Reset
REQ-027 On rst low, the block SHALL asynchronously:
  - empty all queues;
  - set rr=0;
  - drive all cdb_* outputs to 0;
  - clear perf_full_cycles (when present).
REQ-028 req_ready SHALL be all-ones from the first edge after reset deassertion.
REQ-029 Reset asserted mid-transfer SHALL discard all queued and in-flight entries.

Configuration
REQ-030 When CDB_PERF_EN is defined, perf_full_cycles SHALL behave as follows:
  - increment once per cycle in which any queue is full;
  - saturate at 16'hFFFF;
  - clear on rst only, not on flush.
REQ-031 When CDB_PERF_EN is undefined, the port and its counter SHALL be absent, with no other behavioural change.

Structure
REQ-032 Shared package cdb_pkg SHALL hold:
  - NUM_REQ;
  - source ID constants SRC_ALU=0, SRC_MUL=1, SRC_DIV=2, SRC_LOAD=3, SRC_CSR=4;
  - typedef cdb_entry_t {value[31:0], inst_num[31:0], exc, cause[1:0]}.
REQ-033 Per-requester storage SHALL be a sub-module cdb_req_fifo, instantiated NUM_REQ times, with push/pop/full/empty/flush ports.

Verification
REQ-034 Single ALU push value=32'h1234, tag=7 -> next cycle cdb_valid=1, cdb_value=32'h1234, cdb_inst_num=7, cdb_src=0; the cycle after, cdb_valid=0.
REQ-035 All five requesters push in the same cycle with rr=0 -> broadcasts in src order 0,1,2,3,4 on five consecutive cycles; rr ends at 0.
REQ-036 DIV pushes exc=1, cause=2'b01 -> broadcast carries cdb_exc=1, cdb_cause=2'b01, cdb_src=2.
REQ-037 LOAD pushes every cycle while ALU also pushes every cycle, QDEPTH=2:
  - grants alternate between ALU and LOAD;
  - neither requester starves;
  - req_ready[3] drops when LOAD occupancy reaches 2;
  - with CDB_PERF_EN defined, perf_full_cycles increments during those cycles.
REQ-038 Two entries queued in MUL, then flush together with a new MUL push -> cdb_valid=0 on the next two edges, req_ready=5'b11111, and the pushed entry is never broadcast.
REQ-039 rst low while queues are non-empty -> outputs are 0 immediately; after release, the first broadcast carries only post-reset pushes.
